// File: rtl/ex_alu_issue_pkg.sv
// ex_pkg: shared ALU opcodes, operand selects, branch conditions and the registered EX control bundle.
package ex_pkg;
    localparam int XLEN = 32;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;
    typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} srca_e;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} brcond_e;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    typedef struct packed {
        alu_op_e         alu_op;
        srca_e           srca;
        logic            srcb;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            jump;
        brcond_e         brcond;
        logic            illegal;
    } ex_ctrl_t;
    // funct3 to ALU op for OP/OP-IMM, ignoring the funct7[5] variants
    function automatic alu_op_e f3_op(input logic [2:0] f3);
        return f3 == 3'd0 ? ALU_ADD :
               f3 == 3'd1 ? ALU_SLL :
               f3 == 3'd2 ? ALU_SLT :
               f3 == 3'd3 ? ALU_SLTU :
               f3 == 3'd4 ? ALU_XOR :
               f3 == 3'd5 ? ALU_SRL :
               f3 == 3'd6 ? ALU_OR : ALU_AND;
    endfunction
endpackage

// File: rtl/ex_alu_issue_if.sv
// ex_alu_issue_if: ID-side inputs, EX-side outputs and ALU flag feedback of the ID/EX stage.
interface ex_alu_issue_if #(parameter int XLEN = 32);
    logic            id_valid;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic            stall;
    logic            flush;
    logic            ex_valid;
    logic [3:0]      ALUControl;
    logic [1:0]      ALUSrcA;
    logic            ALUSrcB;
    logic [XLEN-1:0] Imm;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      rd;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            Jump;
    logic [2:0]      BranchCond;
    logic            Illegal;
    logic            Zero;
    logic            Negative;
    logic            BranchTaken;
    modport master (
        output id_valid, id_instr, id_pc, stall, flush, Zero, Negative,
        input  ex_valid, ALUControl, ALUSrcA, ALUSrcB, Imm, ex_pc, rd,
               RegWrite, MemRead, MemWrite, Jump, BranchCond, Illegal, BranchTaken
    );
    modport slave (
        input  id_valid, id_instr, id_pc, stall, flush, Zero, Negative,
        output ex_valid, ALUControl, ALUSrcA, ALUSrcB, Imm, ex_pc, rd,
               RegWrite, MemRead, MemWrite, Jump, BranchCond, Illegal, BranchTaken
    );
endinterface

// File: rtl/ex_alu_issue_decode.sv
// ex_decode: combinational RV32I instruction to EX control bundle decoder.
import ex_pkg::*;
module ex_decode (
    input  logic [31:0] instr,
    output ex_ctrl_t    ctrl
);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic        ill;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    always_comb begin
        ctrl = '0;
        ill = 1'b0;
        ctrl.rd = instr[11:7];
        case (opc)
            OP: begin
                ctrl.regwrite = 1'b1;
                ctrl.alu_op = f7 == 7'h20 ? (f3 == 3'd0 ? ALU_SUB : ALU_SRA) : f3_op(f3);
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            OP_IMM: begin
                ctrl.regwrite = 1'b1;
                ctrl.srcb = 1'b1;
                // shift amounts only: the ALU shifts by the full operand, so funct7 must stay out of Imm
                ctrl.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, instr[24:20]} : i_imm;
                ctrl.alu_op = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : f3_op(f3);
                ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.srca = SRCA_ZERO;
                ctrl.srcb = 1'b1;
                ctrl.imm = u_imm;
            end
            AUIPC: begin
                ctrl.regwrite = 1'b1;
                ctrl.srca = SRCA_PC;
                ctrl.srcb = 1'b1;
                ctrl.imm = u_imm;
            end
            LOAD: begin
                ctrl.regwrite = 1'b1;
                ctrl.memread = 1'b1;
                ctrl.srcb = 1'b1;
                ctrl.imm = i_imm;
            end
            STORE: begin
                ctrl.memwrite = 1'b1;
                ctrl.srcb = 1'b1;
                ctrl.imm = s_imm;
            end
            BRANCH: begin
                ctrl.alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                ctrl.brcond = brcond_e'(f3[2] ? f3 - 3'd1 : f3 + 3'd1);
                ctrl.imm = b_imm;
                ill = f3[2:1] == 2'b01;
            end
            JAL: begin
                ctrl.regwrite = 1'b1;
                ctrl.jump = 1'b1;
                ctrl.srca = SRCA_PC;
                ctrl.srcb = 1'b1;
                ctrl.imm = j_imm;
            end
            JALR: begin
                ctrl.regwrite = 1'b1;
                ctrl.jump = 1'b1;
                ctrl.srcb = 1'b1;
                ctrl.imm = i_imm;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            ctrl.alu_op = ALU_ADD;
            ctrl.regwrite = 1'b0;
            ctrl.memread = 1'b0;
            ctrl.memwrite = 1'b0;
            ctrl.jump = 1'b0;
            ctrl.brcond = BR_NONE;
            ctrl.illegal = 1'b1;
        end
        if (!ctrl.regwrite) ctrl.rd = '0;
    end
endmodule

// File: rtl/ex_alu_issue.sv
// ex_alu_issue: ID/EX register with flush/stall priority and branch resolution from ALU flags.
import ex_pkg::*;
module ex_alu_issue #(
    parameter int XLEN           = 32,
    parameter bit RESET_PC_VALID = 1'b0
) (
    input logic           clk,
    input logic           reset,
    ex_alu_issue_if.slave bus
);
    ex_ctrl_t        dec, q;
    logic            valid, bubble;
    logic [XLEN-1:0] pc;
    logic            unused_negative;
    ex_decode u_dec (.instr(bus.id_instr), .ctrl(dec));
    assign bubble = bus.flush | (!bus.stall & !bus.id_valid);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= RESET_PC_VALID;
            q <= '0;
            pc <= '0;
        end else if (bubble) begin
            valid <= 1'b0;
            q <= '0;
        end else if (!bus.stall) begin
            valid <= 1'b1;
            q <= dec;
            pc <= bus.id_pc;
        end
    end
    assign bus.ex_valid   = valid;
    assign bus.ALUControl = q.alu_op;
    assign bus.ALUSrcA    = q.srca;
    assign bus.ALUSrcB    = q.srcb;
    assign bus.Imm        = q.imm;
    assign bus.ex_pc      = pc;
    assign bus.rd         = q.rd;
    assign bus.RegWrite   = q.regwrite;
    assign bus.MemRead    = q.memread;
    assign bus.MemWrite   = q.memwrite;
    assign bus.Jump       = q.jump;
    assign bus.BranchCond = q.brcond;
    assign bus.Illegal    = q.illegal;
    // SLT/SLTU yield 1 when the "less" condition holds, so Zero means "not less"
    assign bus.BranchTaken = valid & (q.jump |
        ((q.brcond inside {BR_EQ, BR_GE, BR_GEU}) & bus.Zero) |
        ((q.brcond inside {BR_NE, BR_LT, BR_LTU}) & !bus.Zero));
    assign unused_negative = bus.Negative;
endmodule

// File: doc/ex_alu_issue.md
Name: ex_alu_issue

Overview:
- ID/EX pipeline stage for the RV32I core.
- Decodes the ID-stage instruction into the 4-bit ALU operation code, operand selects, immediate and branch condition, and registers them for the EX-stage ALU.
- Interprets the ALU's Zero/Negative flags for branches, closing the loop with the ALU.
- Supports stall (hold), flush (bubble) and illegal-instruction flagging.

Parameters:
- XLEN, 32, datapath width of PC and immediate.
- RESET_PC_VALID, 0, value of ex_valid after reset (0 means bubble).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_instr  in  32  instruction word.
- id_pc  in  XLEN  PC of id_instr.
- stall  in  1  hold EX register contents.
- flush  in  1  replace next EX contents with a bubble.
- ex_valid  out  1  EX holds a real instruction.
- ALUControl  out  4  ALU operation code.
- ALUSrcA  out  2  operand-A select: 0 rs1, 1 PC, 2 zero.
- ALUSrcB  out  1  operand-B select: 0 rs2, 1 Imm.
- Imm  out  XLEN  decoded immediate.
- ex_pc  out  XLEN  PC of the EX instruction.
- rd  out  5  destination register.
- RegWrite, MemRead, MemWrite, Jump  out  1 each  control bits.
- BranchCond  out  3  0 none, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU.
- Illegal  out  1  unsupported encoding in EX.
- Zero  in  1  ALU zero flag, same cycle.
- Negative  in  1  ALU negative flag; unused for branches, kept for debug.
- BranchTaken  out  1  combinational branch/jump decision from EX.

Behaviour:
- ALUControl encoding: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU. Codes 10-15 are never driven.
- Decode is combinational from id_instr; the result is registered on the rising clk edge.
- Latency: 1 cycle from the ID input to the EX outputs.
- Decode table:
  - OP / OP-IMM: funct3 to op. funct7[5] selects SUB (OP only) or SRA/SRAI.
  - LUI: ADD, SrcA zero, SrcB imm.
  - AUIPC: ADD, SrcA PC, SrcB imm.
  - LOAD / STORE: ADD, SrcB imm.
  - BRANCH: BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU; SrcB rs2.
  - JAL: ADD, SrcA PC. JALR: ADD, SrcA rs1. Both set Jump and RegWrite.
- Shift immediates: Imm = {27'b0, instr[24:20]}. The ALU shifts by full rs2, so bit 30 must not leak into Imm.
- Illegal encodings: unknown opcode; OP with funct7 not in {0x00, 0x20}; funct7 0x20 with funct3 not ADD/SRL; slli/srli/srai with a wrong funct7.
  - Sets Illegal=1, ex_valid=1, ALUControl=ADD, and clears RegWrite, MemRead, MemWrite, Jump and BranchCond.
- Register update priority: reset > flush > stall > load.
  - flush: ex_valid=0, all control bits 0, BranchCond 0, Illegal 0. Data fields (Imm, ex_pc, rd, ALUControl) may keep stale values.
  - stall without flush: every register holds.
  - id_valid=0 with no stall: loads a bubble, same as flush.
- Flush and stall in the same cycle: flush wins.
- Reset (asynchronous, any time, including mid-stall):
  - ex_valid = RESET_PC_VALID.
  - All other outputs 0: ALUControl=0, ALUSrcA=0, ALUSrcB=0, Imm=0, ex_pc=0, rd=0, controls 0, BranchCond 0, Illegal 0.
- BranchTaken, evaluated only when ex_valid=1, else 0:
  - Jump=1: taken.
  - EQ: Zero. NE: !Zero.
  - LT / LTU: !Zero. GE / GEU: Zero. (The SLT/SLTU result is 1 or 0.)
- rd is forced to 0 when RegWrite=0.

Decomposition:
- Package ex_pkg holds:
  - alu_op_e: 4-bit enum matching the encoding above.
  - srca_e and brcond_e enums.
  - Opcode constants: OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR.
  - A packed struct ex_ctrl_t holding all registered control fields.
- One sub-module, ex_decode: a purely combinational instruction-to-ex_ctrl_t decoder.
- The top level holds the register, the flush/stall priority and the BranchTaken logic.

Test Plan:
- Reset asserted mid-stream with stall=1 -> all outputs 0 immediately, without waiting for a clock edge.
- id_instr=0x40A3D233 (sra x4,x7,x10), valid -> next cycle: ALUControl=7, ALUSrcB=0, RegWrite=1, rd=4, Illegal=0.
- id_instr=0x4053D213 (srai x4,x7,5) -> ALUControl=7, ALUSrcB=1, Imm=5 (not 0x405).
- bge (0x0020D463) in EX with Zero=1 -> BranchTaken=1. Same instruction with Zero=0 -> BranchTaken=0. BranchCond=4, ALUControl=8.
- Load add, then assert stall and flush together while presenting xor -> ex_valid=0 and RegWrite=0. Next cycle with stall only -> stays a bubble.
- id_instr=0x02000033 (mul, funct7=0x01) -> Illegal=1, RegWrite=0, ex_valid=1, BranchTaken=0.
